// File: rtl/hdx_link_ctrl_if.sv
// Host-side handshake bundle for hdx_link_ctrl: transmit request/accept and
// received-word notification. The controller uses the slave modport.
interface hdx_link_ctrl_if #(
  parameter int DW = 8
);
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/hdx_link_ctrl.sv
// Half-duplex bit-serial frame controller for one bidirectional pad:
// start(1), DW data bits LSB first, stop(0), then TURN released cycles.
module hdx_link_ctrl #(
  parameter int DW   = 8,
  parameter int TURN = 2
) (
  input  logic            clk,
  input  logic            reset,
  hdx_link_ctrl_if.slave  host,
  output logic            pad_i,
  output logic            pad_t,
  input  logic            pad_o
);

  localparam int CMAX = (DW > TURN) ? DW : TURN;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, TX_TURN, RX_DATA, RX_TURN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] txsr_q, txsr_d;
  logic [DW-1:0] rxsr_q, rxsr_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          pad_o_q;
  logic          tx_ready;
  logic [DW-1:0] rx_shift;
  logic          dw_last, turn_last;

  // Incoming line bit enters at the top so the LSB-first word lands aligned.
  if (DW == 1) begin : g_rx_one
    assign rx_shift = pad_o_q;
  end else begin : g_rx_many
    assign rx_shift = {pad_o_q, rxsr_q[DW-1:1]};
  end

  assign dw_last   = (cnt_q == CW'(DW - 1));
  assign turn_last = (cnt_q == CW'(TURN - 1));
  assign tx_ready  = (state_q == IDLE) && !pad_o_q && !reset;

  assign host.tx_ready = tx_ready;
  assign host.rx_valid = rx_valid_q;
  assign host.rx_data  = rx_data_q;
  assign host.busy     = (state_q != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    txsr_d     = txsr_q;
    rxsr_d     = rxsr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    pad_t      = 1'b1;
    pad_i      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pad_o_q) begin
          state_d = RX_DATA;
          cnt_d   = '0;
        end else if (host.tx_valid && tx_ready) begin
          txsr_d  = host.tx_data;
          state_d = TX_START;
        end
      end
      TX_START: begin
        pad_t   = 1'b0;
        pad_i   = 1'b1;
        cnt_d   = '0;
        state_d = TX_DATA;
      end
      TX_DATA: begin
        pad_t  = 1'b0;
        pad_i  = txsr_q[0];
        txsr_d = txsr_q >> 1;
        if (dw_last) begin
          cnt_d   = '0;
          state_d = TX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        pad_t   = 1'b0;
        cnt_d   = '0;
        state_d = TX_TURN;
      end
      RX_DATA: begin
        rxsr_d = rx_shift;
        if (dw_last) begin
          rx_data_d  = rx_shift;
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = RX_TURN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_TURN, RX_TURN: begin
        // The line is ignored here; a stop bit is never checked.
        if (turn_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them
  // update together from the values seen before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      txsr_q     <= '0;
      rxsr_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      pad_o_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txsr_q     <= txsr_d;
      rxsr_q     <= rxsr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      pad_o_q    <= pad_o;
    end
  end

endmodule

// File: tb/tb_hdx_link_ctrl.sv
// Directed bench: two DW=8/TURN=2 controllers sharing a pulled-down line,
// plus a DW=1/TURN=1 pair for the minimum-size frame.
module tb_hdx_link_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_cd;
  logic pad_i_a, pad_t_a, pad_i_b, pad_t_b, line_ab;
  logic pad_i_c, pad_t_c, pad_i_d, pad_t_d, line_cd;

  hdx_link_ctrl_if #(.DW(8)) host_a ();
  hdx_link_ctrl_if #(.DW(8)) host_b ();
  hdx_link_ctrl_if #(.DW(1)) host_c ();
  hdx_link_ctrl_if #(.DW(1)) host_d ();

  assign line_ab = !pad_t_a ? pad_i_a : (!pad_t_b ? pad_i_b : 1'b0);
  assign line_cd = !pad_t_c ? pad_i_c : (!pad_t_d ? pad_i_d : 1'b0);

  hdx_link_ctrl #(.DW(8), .TURN(2)) u_a (
    .clk(clk), .reset(rst_a), .host(host_a),
    .pad_i(pad_i_a), .pad_t(pad_t_a), .pad_o(line_ab));
  hdx_link_ctrl #(.DW(8), .TURN(2)) u_b (
    .clk(clk), .reset(rst_b), .host(host_b),
    .pad_i(pad_i_b), .pad_t(pad_t_b), .pad_o(line_ab));
  hdx_link_ctrl #(.DW(1), .TURN(1)) u_c (
    .clk(clk), .reset(rst_cd), .host(host_c),
    .pad_i(pad_i_c), .pad_t(pad_t_c), .pad_o(line_cd));
  hdx_link_ctrl #(.DW(1), .TURN(1)) u_d (
    .clk(clk), .reset(rst_cd), .host(host_d),
    .pad_i(pad_i_d), .pad_t(pad_t_d), .pad_o(line_cd));

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_clash  = 0;

  always @(negedge clk) if (pad_t_a === 1'b0 && pad_t_b === 1'b0) n_clash++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line bit c cycles after acceptance for an 8-bit frame.
  function automatic logic exp_line(input logic [7:0] data, input int c);
    if (c == 1) return 1'b1;
    if (c <= 9) return data[c-2];
    return 1'b0;
  endfunction

  // Current cycle is the accept cycle; ends 13 cycles later with both idle.
  task automatic xfer(input bit a_to_b, input logic [7:0] data);
    check($sformatf("tx_ready_%s accept", a_to_b ? "a" : "b"),
          a_to_b ? host_a.tx_ready : host_b.tx_ready, 1);
    if (a_to_b) begin host_a.tx_valid = 1'b1; host_a.tx_data = data; end
    else        begin host_b.tx_valid = 1'b1; host_b.tx_data = data; end
    tick();
    host_a.tx_valid = 1'b0;
    host_b.tx_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      logic       st, si, rv;
      logic [7:0] rd;
      st = a_to_b ? pad_t_a : pad_t_b;
      si = a_to_b ? pad_i_a : pad_i_b;
      rv = a_to_b ? host_b.rx_valid : host_a.rx_valid;
      rd = a_to_b ? host_b.rx_data  : host_a.rx_data;
      check($sformatf("pad_t_tx %0h c%0d", data, c), st, (c <= 10) ? 0 : 1);
      if (c <= 10) check($sformatf("pad_i_tx %0h c%0d", data, c), si, exp_line(data, c));
      check($sformatf("rx_valid_rx %0h c%0d", data, c), rv, (c == 11) ? 1 : 0);
      if (c == 11) check($sformatf("rx_data_rx %0h", data), rd, data);
      if (c == 13) begin
        check("busy_a end", host_a.busy, 0);
        check("busy_b end", host_b.busy, 0);
        check("tx_ready_sender end", a_to_b ? host_a.tx_ready : host_b.tx_ready, 1);
      end
      if (c < 13) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_cd = 1'b1;
    host_a.tx_valid = 1'b0; host_a.tx_data = '0;
    host_b.tx_valid = 1'b0; host_b.tx_data = '0;
    host_c.tx_valid = 1'b0; host_c.tx_data = '0;
    host_d.tx_valid = 1'b0; host_d.tx_data = '0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst pad_t_a %0d", i), pad_t_a, 1);
      check($sformatf("rst pad_i_a %0d", i), pad_i_a, 0);
      check($sformatf("rst tx_ready_a %0d", i), host_a.tx_ready, 0);
      check($sformatf("rst rx_valid_a %0d", i), host_a.rx_valid, 0);
      check($sformatf("rst busy_a %0d", i), host_a.busy, 0);
      check($sformatf("rst rx_data_b %0d", i), host_b.rx_data, 0);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_cd = 1'b0;
    #1;
    check("tx_ready_a after release", host_a.tx_ready, 1);
    check("tx_ready_b after release", host_b.tx_ready, 1);

    // A sends 0xA5 to B.
    xfer(1'b1, 8'hA5);

    // Ping-pong: B answers once its tx_ready is up.
    begin
      int w = 0;
      while (host_b.tx_ready !== 1'b1 && w < 20) begin tick(); w++; end
      check("pingpong wait tx_ready_b", host_b.tx_ready, 1);
    end
    xfer(1'b0, 8'h3C);

    // Receive priority: B requests while A's frame is arriving.
    check("prio tx_ready_a", host_a.tx_ready, 1);
    host_a.tx_valid = 1'b1; host_a.tx_data = 8'h81;
    tick();
    host_a.tx_valid = 1'b0;
    tick();
    host_b.tx_valid = 1'b1; host_b.tx_data = 8'h7E;
    for (int c = 2; c <= 13; c++) begin
      check($sformatf("prio tx_ready_b c%0d", c), host_b.tx_ready, (c == 13) ? 1 : 0);
      check($sformatf("prio rx_valid_b c%0d", c), host_b.rx_valid, (c == 11) ? 1 : 0);
      if (c == 11) check("prio rx_data_b", host_b.rx_data, 8'h81);
      if (c < 13) tick();
    end
    tick();
    host_b.tx_valid = 1'b0;
    for (int c = 14; c <= 26; c++) begin
      check($sformatf("prio rx_valid_a c%0d", c), host_a.rx_valid, (c == 24) ? 1 : 0);
      if (c == 24) check("prio rx_data_a", host_a.rx_data, 8'h7E);
      if (c == 26) begin
        check("prio busy_a end", host_a.busy, 0);
        check("prio busy_b end", host_b.busy, 0);
      end
      if (c < 26) tick();
    end

    // Reset A in cycle 5 of its frame; B completes with zero-filled bits.
    check("rstmid tx_ready_a", host_a.tx_ready, 1);
    host_a.tx_valid = 1'b1; host_a.tx_data = 8'hA5;
    tick();
    host_a.tx_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c == 5) rst_a = 1'b1;
      if (c == 6) rst_a = 1'b0;
      if (c == 5) check("rstmid pad_t_a c5", pad_t_a, 0);
      if (c >= 6) check($sformatf("rstmid pad_t_a c%0d", c), pad_t_a, 1);
      if (c == 6) check("rstmid busy_a c6", host_a.busy, 0);
      check($sformatf("rstmid rx_valid_b c%0d", c), host_b.rx_valid, (c == 11) ? 1 : 0);
      check($sformatf("rstmid rx_valid_a c%0d", c), host_a.rx_valid, 0);
      if (c == 11) check("rstmid rx_data_b", host_b.rx_data, 8'h05);
      if (c == 13) begin
        check("rstmid busy_a end", host_a.busy, 0);
        check("rstmid busy_b end", host_b.busy, 0);
      end
      if (c < 13) tick();
    end
    xfer(1'b1, 8'h5A);

    check("no line contention", n_clash, 0);

    // DW=1, TURN=1: back-to-back frames every 5 cycles with tx_valid held.
    begin
      logic bits [3];
      bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1;
      host_c.tx_valid = 1'b1;
      host_c.tx_data  = bits[0];
      for (int f = 0; f < 3; f++) begin
        check($sformatf("dw1 tx_ready_c f%0d", f), host_c.tx_ready, 1);
        tick();
        if (f < 2) host_c.tx_data = bits[f+1];
        else       host_c.tx_valid = 1'b0;
        check($sformatf("dw1 start f%0d", f), line_cd, 1);
        check($sformatf("dw1 pad_t_c s f%0d", f), pad_t_c, 0);
        check($sformatf("dw1 tx_ready_c busy f%0d", f), host_c.tx_ready, 0);
        tick();
        check($sformatf("dw1 data f%0d", f), line_cd, bits[f]);
        check($sformatf("dw1 pad_t_c s1 f%0d", f), pad_t_c, 0);
        tick();
        check($sformatf("dw1 stop f%0d", f), line_cd, 0);
        check($sformatf("dw1 pad_t_c s2 f%0d", f), pad_t_c, 0);
        check($sformatf("dw1 rx_valid_d s2 f%0d", f), host_d.rx_valid, 0);
        tick();
        check($sformatf("dw1 pad_t_c s3 f%0d", f), pad_t_c, 1);
        check($sformatf("dw1 rx_valid_d s3 f%0d", f), host_d.rx_valid, 1);
        check($sformatf("dw1 rx_data_d f%0d", f), host_d.rx_data, bits[f]);
        tick();
        check($sformatf("dw1 busy_d s4 f%0d", f), host_d.busy, 0);
      end
      check("dw1 pad_t_d never driven", pad_t_d, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
